// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring integer divider (DIV/DIVU/REM/REMU).
// One quotient bit per cycle. Divide-by-zero and signed overflow answer in a
// single cycle without iterating.
// Optional macro DIV_CACHE_EN: adds a last-result cache. A request whose
// {dividend, divisor, signed} matches the previous one answers in one cycle.
// Handshake: a request is accepted on an edge where req_valid_i & req_ready_o.
// A response completes on an edge where resp_valid_o & resp_ready_i. Data is
// held stable while valid is high and ready is low.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             signed_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] rem_o,
   output logic             busy_o,
   output logic [1:0]       dbg_state
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t state, next_state;

   logic [2*WIDTH-1:0] pr;        // {partial remainder, dividend/quotient bits}
   logic [WIDTH-1:0]   dvsr;
   logic [CW-1:0]      cnt;
   logic               neg_q, neg_r;

   logic               accept, div_zero, ovf, hit, fast;
   logic               sd, sv;
   logic [WIDTH-1:0]   abs_dvd, abs_dvs;
   logic [WIDTH-1:0]   fast_quot, fast_rem, fix_quot, fix_rem;
   logic [WIDTH:0]     upper, diff;
   logic [2*WIDTH-1:0] pr_next;

`ifdef DIV_CACHE_EN
   logic               c_valid, c_signed, op_signed;
   logic [WIDTH-1:0]   c_dividend, c_divisor, c_quot, c_rem;
   logic [WIDTH-1:0]   op_dividend, op_divisor;
`endif

   // Request decode, corner-case detection and the single restoring step.
   always_comb begin
      accept   = req_valid_i & req_ready_o;
      div_zero = (divisor_i == '0);
      ovf      = signed_i && (dividend_i == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor_i == '1);
`ifdef DIV_CACHE_EN
      hit      = c_valid && (c_dividend == dividend_i) && (c_divisor == divisor_i)
                 && (c_signed == signed_i);
`else
      hit      = 1'b0;
`endif
      fast     = div_zero | ovf | hit;

      sd       = signed_i & dividend_i[WIDTH-1];
      sv       = signed_i & divisor_i[WIDTH-1];
      abs_dvd  = sd ? -dividend_i : dividend_i;
      abs_dvs  = sv ? -divisor_i : divisor_i;

      fast_quot = '1;
      fast_rem  = dividend_i;
      if (!div_zero && ovf) begin
         fast_quot = dividend_i;
         fast_rem  = '0;
      end
`ifdef DIV_CACHE_EN
      else if (!div_zero && hit) begin
         fast_quot = c_quot;
         fast_rem  = c_rem;
      end
`endif

      // Shift left by one, then trial-subtract from the upper WIDTH+1 bits.
      upper = pr[2*WIDTH-1:WIDTH-1];
      diff  = upper - {1'b0, dvsr};
      if (!diff[WIDTH])
         pr_next = {diff[WIDTH-1:0], pr[WIDTH-2:0], 1'b1};
      else
         pr_next = {pr[2*WIDTH-2:0], 1'b0};

      fix_quot = neg_q ? -pr[WIDTH-1:0] : pr[WIDTH-1:0];
      fix_rem  = neg_r ? -pr[2*WIDTH-1:WIDTH] : pr[2*WIDTH-1:WIDTH];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic and status outputs.
   always_comb begin
      next_state   = state;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      busy_o       = (state != IDLE);
      dbg_state    = state;
      case (state)
         IDLE: begin
            req_ready_o = ~rst;
            if (accept) next_state = fast ? DONE : CALC;
         end
         CALC: if (cnt == CW'(WIDTH-1)) next_state = FIX;
         FIX:  next_state = DONE;
         DONE: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Datapath: operand latch, iteration, sign fix-up and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pr     <= '0;
         dvsr   <= '0;
         cnt    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         quot_o <= '0;
         rem_o  <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               if (fast) begin
                  quot_o <= fast_quot;
                  rem_o  <= fast_rem;
               end else begin
                  pr    <= {{WIDTH{1'b0}}, abs_dvd};
                  dvsr  <= abs_dvs;
                  cnt   <= '0;
                  neg_q <= sd ^ sv;
                  neg_r <= sd;
               end
            end
            CALC: begin
               pr  <= pr_next;
               cnt <= cnt + CW'(1);
            end
            FIX: begin
               quot_o <= fix_quot;
               rem_o  <= fix_rem;
            end
            default: ;
         endcase
      end
   end

`ifdef DIV_CACHE_EN
   // Last-result cache: filled whenever a response is produced.
   always_ff @(posedge clk) begin
      if (rst) begin
         c_valid     <= 1'b0;
         c_signed    <= 1'b0;
         c_dividend  <= '0;
         c_divisor   <= '0;
         c_quot      <= '0;
         c_rem       <= '0;
         op_signed   <= 1'b0;
         op_dividend <= '0;
         op_divisor  <= '0;
      end else if (state == IDLE && accept) begin
         op_dividend <= dividend_i;
         op_divisor  <= divisor_i;
         op_signed   <= signed_i;
         if (fast) begin
            c_valid    <= 1'b1;
            c_dividend <= dividend_i;
            c_divisor  <= divisor_i;
            c_signed   <= signed_i;
            c_quot     <= fast_quot;
            c_rem      <= fast_rem;
         end
      end else if (state == FIX) begin
         c_valid    <= 1'b1;
         c_dividend <= op_dividend;
         c_divisor  <= op_divisor;
         c_signed   <= op_signed;
         c_quot     <= fix_quot;
         c_rem      <= fix_rem;
      end
   end
`endif

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed tests for div_unit at WIDTH=8.
module tb_div_unit;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid_i;
   logic         req_ready_o;
   logic [W-1:0] dividend_i;
   logic [W-1:0] divisor_i;
   logic         signed_i;
   logic         resp_valid_o;
   logic         resp_ready_i;
   logic [W-1:0] quot_o;
   logic [W-1:0] rem_o;
   logic         busy_o;
   logic [1:0]   dbg_state;

   int checks = 0;
   int errors = 0;

   div_unit #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .dividend_i   (dividend_i),
      .divisor_i    (divisor_i),
      .signed_i     (signed_i),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready_i),
      .quot_o       (quot_o),
      .rem_o        (rem_o),
      .busy_o       (busy_o),
      .dbg_state    (dbg_state)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issue one request, wait (bounded) for the response, consume it.
   // lat counts edges from the accept edge (1) to the edge that raised resp_valid_o.
   task automatic do_div(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic sgn,
                         output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
      @(negedge clk);
      dividend_i  = dvd;
      divisor_i   = dvs;
      signed_i    = sgn;
      req_valid_i = 1'b1;
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      dividend_i  = W'($urandom_range(0, 255));
      divisor_i   = W'($urandom_range(0, 255));
      signed_i    = ~sgn;
      lat = 1;
      while (!resp_valid_o && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      q = quot_o;
      r = rem_o;
      @(negedge clk);
      resp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      resp_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid_i = 1'b0;
      resp_ready_i = 1'b0;
      dividend_i = '0;
      divisor_i = '0;
      signed_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready_o); end
      checks++;
      if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++; $display("FAIL reset_flags: valid %b busy %b expected 0 0", resp_valid_o, busy_o);
      end
      checks++;
      if (quot_o !== 8'h00 || rem_o !== 8'h00) begin
         errors++; $display("FAIL reset_data: quot %h rem %h expected 00 00", quot_o, rem_o);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (req_ready_o !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b expected 1", req_ready_o); end
   endtask

   task automatic test_unsigned();
      logic [W-1:0] q, r;
      int lat;
      do_div(8'd200, 8'd7, 1'b0, q, r, lat);
      checks++;
      if (q !== 8'd28 || r !== 8'd4) begin errors++; $display("FAIL udiv_200_7: got %0d/%0d expected 28/4", q, r); end
      checks++;
      if (lat !== 10) begin errors++; $display("FAIL udiv_latency: got %0d expected 10", lat); end
      checks++;
      if (busy_o !== 1'b0 || resp_valid_o !== 1'b0) begin
         errors++; $display("FAIL udiv_after_consume: busy %b valid %b expected 0 0", busy_o, resp_valid_o);
      end
   endtask

   task automatic test_cache();
      logic [W-1:0] q, r;
      int lat, exp_lat;
`ifdef DIV_CACHE_EN
      exp_lat = 1;
`else
      exp_lat = 10;
`endif
      do_div(8'd200, 8'd7, 1'b0, q, r, lat);
      checks++;
      if (q !== 8'd28 || r !== 8'd4) begin errors++; $display("FAIL repeat_200_7: got %0d/%0d expected 28/4", q, r); end
      checks++;
      if (lat !== exp_lat) begin errors++; $display("FAIL repeat_latency: got %0d expected %0d", lat, exp_lat); end
      do_div(8'd200, 8'd7, 1'b1, q, r, lat);
      checks++;
      if (q !== 8'hF8 || r !== 8'h00) begin errors++; $display("FAIL sdiv_m56_7: got %h/%h expected f8/00", q, r); end
      checks++;
      if (lat !== 10) begin errors++; $display("FAIL sdiv_m56_7_latency: got %0d expected 10", lat); end
   endtask

   task automatic test_signed();
      logic [W-1:0] dvd_t [5] = '{8'hF9, 8'h07, 8'hF9, 8'h80, 8'h64};
      logic [W-1:0] dvs_t [5] = '{8'h02, 8'hFE, 8'hFE, 8'h01, 8'hF9};
      logic [W-1:0] q_t   [5] = '{8'hFD, 8'hFD, 8'h03, 8'h80, 8'hF2};
      logic [W-1:0] r_t   [5] = '{8'hFF, 8'h01, 8'hFF, 8'h00, 8'h02};
      logic [W-1:0] q, r;
      int lat;
      for (int i = 0; i < 5; i++) begin
         do_div(dvd_t[i], dvs_t[i], 1'b1, q, r, lat);
         checks++;
         if (q !== q_t[i] || r !== r_t[i] || lat !== 10) begin
            errors++;
            $display("FAIL signed_%0d: %h/%h got %h/%h lat %0d expected %h/%h lat 10",
                     i, dvd_t[i], dvs_t[i], q, r, lat, q_t[i], r_t[i]);
         end
      end
   endtask

   task automatic test_unsigned_edges();
      logic [W-1:0] dvd_t [3] = '{8'hFF, 8'hFF, 8'h80};
      logic [W-1:0] dvs_t [3] = '{8'h01, 8'hFF, 8'hFF};
      logic [W-1:0] q_t   [3] = '{8'hFF, 8'h01, 8'h00};
      logic [W-1:0] r_t   [3] = '{8'h00, 8'h00, 8'h80};
      logic [W-1:0] q, r;
      int lat;
      for (int i = 0; i < 3; i++) begin
         do_div(dvd_t[i], dvs_t[i], 1'b0, q, r, lat);
         checks++;
         if (q !== q_t[i] || r !== r_t[i] || lat !== 10) begin
            errors++;
            $display("FAIL unsigned_edge_%0d: %h/%h got %h/%h lat %0d expected %h/%h lat 10",
                     i, dvd_t[i], dvs_t[i], q, r, lat, q_t[i], r_t[i]);
         end
      end
   endtask

   task automatic test_corner();
      logic [W-1:0] q, r;
      int lat;
      for (int s = 0; s < 2; s++) begin
         do_div(8'h5A, 8'h00, s[0], q, r, lat);
         checks++;
         if (q !== 8'hFF || r !== 8'h5A || lat !== 1) begin
            errors++; $display("FAIL div_zero_s%0d: got %h/%h lat %0d expected ff/5a lat 1", s, q, r, lat);
         end
      end
      do_div(8'h80, 8'hFF, 1'b1, q, r, lat);
      checks++;
      if (q !== 8'h80 || r !== 8'h00 || lat !== 1) begin
         errors++; $display("FAIL overflow: got %h/%h lat %0d expected 80/00 lat 1", q, r, lat);
      end
   endtask

   task automatic test_backpressure();
      int n;
      @(negedge clk);
      dividend_i = 8'd100;
      divisor_i = 8'd9;
      signed_i = 1'b0;
      req_valid_i = 1'b1;
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      n = 0;
      while (!resp_valid_o && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         dividend_i = W'($urandom_range(0, 255));
         divisor_i = W'($urandom_range(1, 255));
         signed_i = i[0];
         req_valid_i = 1'b1;
         @(posedge clk);
         #1;
         checks++;
         if (quot_o !== 8'd11 || rem_o !== 8'd1 || resp_valid_o !== 1'b1 || req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_%0d: got %0d/%0d valid %b ready %b expected 11/1 valid 1 ready 0",
                     i, quot_o, rem_o, resp_valid_o, req_ready_o);
         end
      end
      @(negedge clk);
      req_valid_i = 1'b0;
      resp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      resp_ready_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0 || resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_release: busy %b valid %b ready %b expected 0 0 1",
                  busy_o, resp_valid_o, req_ready_o);
      end
   endtask

   task automatic test_reset_mid_calc();
      logic [W-1:0] q, r;
      int lat;
      @(negedge clk);
      dividend_i = 8'd200;
      divisor_i = 8'd7;
      signed_i = 1'b0;
      req_valid_i = 1'b1;
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (resp_valid_o !== 1'b0 || busy_o !== 1'b0 || quot_o !== 8'h00 || rem_o !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid_calc: valid %b busy %b data %h/%h expected 0 0 00/00",
                  resp_valid_o, busy_o, quot_o, rem_o);
      end
      #1;
      checks++;
      if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_mid_calc_ready: got %b expected 1", req_ready_o); end
      do_div(8'd200, 8'd7, 1'b0, q, r, lat);
      checks++;
      if (q !== 8'd28 || r !== 8'd4 || lat !== 10) begin
         errors++; $display("FAIL after_reset_200_7: got %0d/%0d lat %0d expected 28/4 lat 10", q, r, lat);
      end
   endtask

   task automatic test_back_to_back();
      int lat, gap;
      // resp_ready_i already high: response lasts exactly one DONE cycle.
      @(negedge clk);
      dividend_i = 8'd50;
      divisor_i = 8'd6;
      signed_i = 1'b0;
      req_valid_i = 1'b1;
      resp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      dividend_i = 8'd9;
      divisor_i = 8'd0;
      lat = 1;
      while (!resp_valid_o && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (quot_o !== 8'd8 || rem_o !== 8'd2 || lat !== 10) begin
         errors++; $display("FAIL b2b_first: got %0d/%0d lat %0d expected 8/2 lat 10", quot_o, rem_o, lat);
      end
      // req_valid_i stayed high: next accept on the edge after the consume.
      gap = 0;
      @(posedge clk);
      #1;
      while (!resp_valid_o && gap < 100) begin
         @(posedge clk);
         #1;
         gap++;
      end
      req_valid_i = 1'b0;
      checks++;
      if (quot_o !== 8'hFF || rem_o !== 8'd9 || gap !== 1) begin
         errors++; $display("FAIL b2b_second: got %h/%h gap %0d expected ff/09 gap 1", quot_o, rem_o, gap);
      end
      @(posedge clk);
      #1;
      resp_ready_i = 1'b0;
      checks++;
      if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++; $display("FAIL b2b_done: valid %b busy %b expected 0 0", resp_valid_o, busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_cache();
      test_signed();
      test_unsigned_edges();
      test_corner();
      test_backpressure();
      test_reset_mid_calc();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_unit.md
# div_unit

Parametrised iterative integer divider for the RISC-V execute stage, serving DIV/DIVU/REM/REMU. Computes quotient and remainder of two WIDTH-bit operands, signed or unsigned, with one quotient bit per cycle (restoring, radix-2). Requests and responses each use a valid/ready handshake, so the pipeline can stall on either side. RISC-V corner cases (divide-by-zero, signed overflow) are resolved without iterating.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  divider can accept a request
- dividend_i  in  WIDTH  dividend (rs1)
- divisor_i  in  WIDTH  divisor (rs2)
- signed_i  in  1  1 = two's-complement operands, 0 = unsigned
- resp_valid_o  out  1  quot_o/rem_o valid
- resp_ready_i  in  1  consumer takes response
- quot_o  out  WIDTH  quotient
- rem_o  out  WIDTH  remainder
- busy_o  out  1  high in any state but IDLE

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: req_ready_o=1. On accept (req_valid_i & req_ready_o), latch operands and signed_i.
  - divisor == 0 -> DONE; quot = all ones, rem = dividend.
  - signed & dividend == 2^(WIDTH-1) & divisor == all ones -> DONE; quot = dividend, rem = 0.
  - cache hit (see Configuration) -> DONE with cached results.
  - otherwise -> CALC with: |dividend| in the low half of a 2*WIDTH partial remainder; |divisor| (absolute value when signed, raw value when unsigned); step counter = 0; sign flags neg_q = sd^sv and neg_r = sd (signed only, else 0).
- CALC: each cycle:
  - shift the partial remainder left 1;
  - trial-subtract divisor from the upper WIDTH+1 bits;
  - if the result is non-negative, keep it and shift in quotient bit 1; else restore and shift in 0;
  - counter++.
  - After WIDTH steps (counter == WIDTH-1 on the last step) -> FIX.
- FIX: apply signs. quot = neg_q ? -q : q; rem = neg_r ? -r : r (truncating division; the remainder takes the dividend's sign). Register results -> DONE.
- DONE: resp_valid_o=1. quot_o/rem_o are held stable until resp_ready_i; then -> IDLE.
- Arithmetic: all negation is two's complement modulo 2^WIDTH. The trial subtract is WIDTH+1 bits wide, so there is no overflow for the unsigned maximum.
- Outputs are registered, and change only on entering DONE.

## Timing
- Reset values: req_ready_o=0 during the reset cycle, then 1 in IDLE; resp_valid_o=0; busy_o=0; quot_o=0; rem_o=0; counter=0; cache invalid.
- Normal latency: resp_valid_o rises WIDTH+2 cycles after the accept edge (WIDTH CALC + 1 FIX + entry to DONE).
- Fast paths (zero divisor, overflow, cache hit): resp_valid_o rises 1 cycle after the accept edge.
- req_ready_o=0 in CALC/FIX/DONE. Only one operation is in flight at a time.
- Handshake rules:
  - Inputs are sampled only on the accept edge; later changes are ignored.
  - resp_valid_o and data hold while resp_ready_i=0.
  - A response completes on the edge where resp_valid_o & resp_ready_i. The next request is accepted at the earliest on the following edge; throughput is therefore WIDTH+3 cycles per divide.
- resp_ready_i already high on entering DONE: the response is consumed in a single DONE cycle.
- rst at any cycle, including mid-CALC or in DONE: the operation is aborted, all outputs return to reset values on the next edge, and no response is produced.

## Configuration
- DIV_CACHE_EN defined: a last-result cache is built in.
  - It holds {dividend, divisor, signed, quot, rem} from the last completed response; it is written on FIX->DONE and on the fast paths.
  - An accept with an identical {dividend, divisor, signed} triple is a hit: DONE in 1 cycle.
  - This covers DIV followed by REM on the same operands.
  - Reset invalidates the cache.
- DIV_CACHE_EN undefined: no cache storage; every non-corner request takes the full WIDTH+2 cycles.

## Test plan
- WIDTH=8, unsigned 200/7 -> quot_o=28, rem_o=4; resp_valid_o exactly 10 cycles after accept.
- Signed, WIDTH=8: 0xF9/0x02 (-7/2) -> quot 0xFD, rem 0xFF; 0x07/0xFE (7/-2) -> quot 0xFD, rem 0x01; 0xF9/0xFE -> quot 0x03, rem 0xFF.
- Corner cases, WIDTH=8:
  - 0x5A/0x00 (both modes) -> quot 0xFF, rem 0x5A, 1-cycle latency.
  - Signed 0x80/0xFF -> quot 0x80, rem 0x00, 1-cycle latency.
  - Unsigned 0x80/0xFF -> quot 0, rem 0x80, full latency.
- Backpressure: hold resp_ready_i=0 for 5 cycles in DONE, changing the dividend_i/divisor_i/req_valid_i inputs -> quot_o/rem_o stable, req_ready_o=0, no new accept.
- Reset at CALC step 3 -> next cycle resp_valid_o=0, busy_o=0, req_ready_o=1; the following 200/7 returns 28/4 normally.
- With DIV_CACHE_EN: repeat 200/7 unsigned -> 1-cycle response 28/4; same operands with signed_i=1 -> full latency, quot 0xF8 (-56/7 = -8), rem 0. Without the macro: the repeat takes 10 cycles.
